// File: rtl/apb_pkg.sv
// Shared types and address-decode helper for the APB bridge family.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DECERR = 2'd3
    } apb_state_e;

    localparam logic [31:0] SLOT_SIZE  = 32'h1000;
    localparam int unsigned SLOT_SHIFT = 12;

    // Offset is taken modulo 2**aw, so an address below base wraps high and misses.
    function automatic logic [4:0] slot_decode(input logic [63:0]  addr,
                                               input logic [63:0]  base,
                                               input logic [63:0]  n,
                                               input int unsigned  aw);
        logic [63:0] mask;
        logic [63:0] off;
        logic [63:0] span;
        logic [63:0] idx;
        mask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
        off  = (addr - base) & mask;
        span = n * {32'd0, SLOT_SIZE};
        idx  = off >> SLOT_SHIFT;
        slot_decode = {(off < span), idx[3:0]};
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB slot decoder: address in, hit flag and one-hot slot select out.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 6,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000_0000
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  hit_o,
    output logic [NUM_SLAVES-1:0] sel_o
);

    logic [4:0] dec;

    always_comb begin
        dec   = slot_decode(64'(addr_i), 64'(BASE_ADDR), 64'(NUM_SLAVES), ADDR_W);
        hit_o = dec[4];
        sel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_o[i] = dec[4] && (dec[3:0] == 4'(i));
        end
    end

endmodule

// File: rtl/apb_bridge_n.sv
// CPU-to-APB bridge for NUM_SLAVES slots with per-slave error return and
// a wait-state timeout that completes hung or unmapped accesses with error.
module apb_bridge_n
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 6,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000_0000,
    parameter int                TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         error,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      paddr_q, paddr_d;
    logic                   pwrite_q, pwrite_d;
    logic [DATA_W-1:0]      pwdata_q, pwdata_d;
    logic [NUM_SLAVES-1:0]  sel_q, sel_d;
    logic [NUM_SLAVES-1:0]  psel_q, psel_d;
    logic                   penable_q, penable_d;

    logic                   dec_hit;
    logic [NUM_SLAVES-1:0]  dec_sel;
    logic                   slv_ready;
    logic                   slv_err;
    logic [DATA_W-1:0]      slv_rdata;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .addr_i (addr),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel)
    );

    // Only the latched slot contributes; other slaves' responses are masked out.
    always_comb begin
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                slv_ready = slv_ready | PREADY[i];
                slv_err   = slv_err   | PSLVERR[i];
                slv_rdata = slv_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            sel_q     <= sel_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        sel_d    = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    paddr_d  = addr;
                    pwrite_d = write;
                    pwdata_d = wdata;
                    sel_d    = dec_sel;
                    state_d  = dec_hit ? ST_SETUP : ST_DECERR;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (slv_ready || (cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECERR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state; the CPU response is combinational.
    always_comb begin
        psel_d    = ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) ? sel_d : '0;
        penable_d = (state_d == ST_ACCESS);
        ready     = 1'b0;
        error     = 1'b0;
        rdata     = '0;
        case (state_q)
            ST_ACCESS: begin
                if (slv_ready) begin
                    ready = 1'b1;
                    error = slv_err;
                    rdata = pwrite_q ? '0 : slv_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    ready = 1'b1;
                    error = 1'b1;
                end
            end
            ST_DECERR: begin
                ready = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;

endmodule

// File: doc/apb_bridge_n.md
# apb_bridge_n

Parametrised APB bridge between the RV32I CPU data bus and N APB peripherals (RAM, GPO, GPI, GPIO, FND, UART, and future slots). It replaces the fixed six-slave master with three additions:

- a configurable slave count and address map;
- per-slave PSLVERR propagation;
- a wait-state timeout that turns hung or unmapped accesses into an error completion instead of a CPU stall.

## Interface
Parameters:
- NUM_SLAVES, 6, number of APB slave slots (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- BASE_ADDR, 32'h1000_0000, base of slot 0; slot i occupies BASE_ADDR + i*0x1000, 4 KiB each
- TIMEOUT, 255, max ACCESS cycles without PREADY before forced error (1..65535)

Ports:
- PCLK  in  1  bus clock; the only clock
- PRESET  in  1  asynchronous, active-low reset
- transfer  in  1  CPU request strobe, sampled in IDLE
- write  in  1  1 = write, 0 = read
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- error  out  1  qualifies ready; 1 = slave error, timeout or unmapped address
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB access phase
- PWDATA  out  DATA_W  APB write data
- PSEL  out  NUM_SLAVES  one-hot slave select
- PRDATA  in  NUM_SLAVES*DATA_W  flattened read data; slot i at [i*DATA_W +: DATA_W]
- PREADY  in  NUM_SLAVES  per-slave ready
- PSLVERR  in  NUM_SLAVES  per-slave error

## Operation
States: IDLE, SETUP, ACCESS, DECERR.

- **IDLE:** PSEL=0, PENABLE=0. On transfer=1:
  - latch addr/write/wdata into PADDR/PWRITE/PWDATA;
  - decode the slot;
  - go to SETUP if the address is mapped, otherwise go to DECERR.
- **SETUP:**
  - PSEL[slot]=1, PENABLE=0, clear the wait counter;
  - always go to ACCESS next cycle.
- **ACCESS:**
  - PSEL[slot]=1, PENABLE=1.
  - If PREADY[slot]=1: ready=1, error=PSLVERR[slot], rdata=PRDATA slot (0 on writes), then go to IDLE.
  - Else, if the counter equals TIMEOUT-1: ready=1, error=1, rdata=0, then go to IDLE.
  - Else: increment the counter.
- **DECERR:**
  - no PSEL asserted;
  - ready=1, error=1, rdata=0;
  - go to IDLE.

Decode rules:
- Mapped means BASE_ADDR ≤ addr < BASE_ADDR + NUM_SLAVES*0x1000.
- Slot index is (addr - BASE_ADDR) >> 12.
- Arithmetic is done in ADDR_W bits. An address below the base wraps to a large value and so falls out of range.

Output and busy rules:
- PADDR, PWRITE and PWDATA hold their latched values from SETUP until the next IDLE capture.
- PSEL and PENABLE must never be 1 outside SETUP/ACCESS.
- transfer is ignored outside IDLE. The CPU holds the request until ready.
- The counter width is ceil(log2(TIMEOUT+1)). It saturates and never wraps.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0. Reset is effective immediately (asynchronous).
- Reset asserted mid-transfer drops PSEL/PENABLE at once. The in-flight access is lost with no ready pulse.
- ready, error and rdata are combinational from state and PREADY/PSLVERR/PRDATA; all other outputs are registered.
- Zero-wait slave, with transfer seen at cycle 0:
  - cycle 1: SETUP;
  - cycle 2: ACCESS with ready=1;
  - cycle 3: IDLE.
  - Total latency is 2 cycles, and the next transfer is accepted at cycle 3.
- Each slave wait state adds one cycle.
- Timeout: ready fires in ACCESS cycle number TIMEOUT, counting the first ACCESS cycle as 1.
- PREADY and the timeout in the same cycle: PREADY wins and error=PSLVERR.
- Unmapped address: ready on the cycle after capture.
- PREADY/PSLVERR/PRDATA of unselected slots are ignored.

## Structure
- Package apb_pkg holds:
  - state enum apb_state_e;
  - constant SLOT_SIZE = 32'h1000;
  - function slot_decode(addr, base, n) returning {hit, index}.
- One sub-module, apb_addr_decoder: combinational, takes addr and produces the hit flag plus the one-hot slot. It is reusable by the future AHB-to-APB bridge.
- The main FSM, counter and data-return mux stay in apb_bridge_n.

## Test plan
- Read from a zero-wait slot: addr=0x1000_2004, slave 2 PRDATA=0x0000_00A5, PREADY=1 → PSEL=3'b100 pattern, ready on cycle 2, rdata=0x0000_00A5, error=0.
- Write with wait states: addr=0x1000_5000, wdata=0x1234_5678, slave 5 holds PREADY low 3 cycles → PENABLE high 4 cycles, PWDATA stable, ready on cycle 5, error=0.
- Slave error: slave 1 returns PREADY=1 with PSLVERR=1 → ready=1 and error=1 in the same cycle.
- Timeout: TIMEOUT=4, slave 3 never ready → ready=1, error=1, rdata=0 in the 4th ACCESS cycle; PSEL=0 the next cycle.
- Unmapped address 0x1000_6000 (NUM_SLAVES=6) and 0x0FFF_FFFC → no PSEL asserted, ready=1 and error=1 one cycle after transfer.
- Reset mid-ACCESS: assert PRESET=0 while slave 0 is waiting → PSEL, PENABLE, PADDR and ready are 0 immediately; a fresh transfer after release completes normally.
